feature_addr_gen: RTL and testbench

- Downstream of the base-address decoder. Latches up to three 19-bit feature-map base addresses for one opcode.
- Streams one feature-memory read address per accepted beat over a valid/ready handshake.
- Scan order: feature-major, then row, then column, over an IMG_H x IMG_W map.
- Feeds the feature-buffer read port of the conv datapath.

---
 rtl/feature_addr_gen_pkg.sv | 23 ++
 rtl/feature_scan_cnt.sv | 54 +++++
 rtl/feature_addr_gen.sv | 170 +++++++++++++++++
 tb/tb_feature_addr_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_addr_gen_pkg.sv
// rtl/feature_addr_gen_pkg.sv - feature-memory constants and FSM encoding for feature_addr_gen
package feature_addr_gen_pkg;

  localparam int FEAT_ADDR_W    = 19;
  localparam int FEAT_IMG_W     = 64;
  localparam int FEAT_IMG_H     = 64;
  localparam int FEAT_ROW_SHIFT = 6;
  localparam int FEAT_CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } featState_t;

  // Last index visited along one axis of length len when stepping by 1 or 2.
  function automatic logic [FEAT_CNT_W-1:0] lastIndex(input int len, input logic stride2);
    int lastVal;
    lastVal = stride2 ? (len - 2) : (len - 1);
    return FEAT_CNT_W'(lastVal);
  endfunction

endpackage

// File: rtl/feature_scan_cnt.sv
// rtl/feature_scan_cnt.sv - row/column scan counter with step and wrap flags
module feature_scan_cnt
  import feature_addr_gen_pkg::*;
#(
  parameter int IMG_W = FEAT_IMG_W,
  parameter int IMG_H = FEAT_IMG_H,
  parameter int CNT_W = FEAT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             advance,
  input  logic             stride2,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             planeLast
);

  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] lastCol;
  logic [CNT_W-1:0] lastRow;
  logic             colLast;
  logic             rowLast;

  assign step      = stride2 ? CNT_W'(2) : CNT_W'(1);
  assign lastCol   = lastIndex(IMG_W, stride2);
  assign lastRow   = lastIndex(IMG_H, stride2);
  assign colLast   = (col == lastCol);
  assign rowLast   = (row == lastRow);
  assign planeLast = colLast & rowLast;

  // Column steps every accepted beat; row steps when the column wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (colLast) begin
        col <= '0;
        if (rowLast) begin
          row <= '0;
        end else begin
          row <= row + step;
        end
      end else begin
        col <= col + step;
      end
    end
  end

endmodule

// File: rtl/feature_addr_gen.sv
// rtl/feature_addr_gen.sv - feature-map read address streamer; optional stride-2 scan under FEAT_ADDR_STRIDE2_EN
module feature_addr_gen
  import feature_addr_gen_pkg::*;
#(
  parameter int ADDR_W    = FEAT_ADDR_W,
  parameter int IMG_W     = FEAT_IMG_W,
  parameter int IMG_H     = FEAT_IMG_H,
  parameter int ROW_SHIFT = FEAT_ROW_SHIFT
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_baseAddr0,
  input  logic [ADDR_W-1:0] i_baseAddr1,
  input  logic [ADDR_W-1:0] i_baseAddr2,
  input  logic [1:0]        i_numFeat,
  input  logic              i_stride2,
  input  logic              i_abort,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_featSel,
  output logic [5:0]        o_row,
  output logic [5:0]        o_col,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  featState_t state;
  featState_t stateNext;

  logic [ADDR_W-1:0] base0Q;
  logic [ADDR_W-1:0] base1Q;
  logic [ADDR_W-1:0] base2Q;
  logic [1:0]        numFeatQ;
  logic [1:0]        featQ;
  logic              stride2Q;

  logic [5:0]        row;
  logic [5:0]        col;
  logic              planeLast;

  logic              startJob;
  logic              xfer;
  logic              isRun;
  logic              isDone;
  logic              lastBeat;
  logic [ADDR_W-1:0] baseSel;
  logic [ADDR_W-1:0] addrCalc;

`ifdef FEAT_ADDR_STRIDE2_EN
  // Stride mode is fixed for the whole job, captured with the bases.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stride2Q <= 1'b0;
    end else if (startJob) begin
      stride2Q <= i_stride2;
    end
  end
`else
  logic unusedStride2;
  assign unusedStride2 = i_stride2;
  assign stride2Q      = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state plus the start/transfer strobes; abort beats a pending transfer.
  always_comb begin
    stateNext = state;
    startJob  = 1'b0;
    xfer      = 1'b0;
    isRun     = 1'b0;
    isDone    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          startJob  = 1'b1;
          stateNext = (i_numFeat != 2'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        isRun = 1'b1;
        if (i_abort) begin
          stateNext = ST_IDLE;
        end else if (i_ready) begin
          xfer = 1'b1;
          if (lastBeat) begin
            stateNext = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        isDone    = 1'b1;
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Job parameters latched at start; feature index steps when a plane wraps.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      base0Q   <= '0;
      base1Q   <= '0;
      base2Q   <= '0;
      numFeatQ <= '0;
      featQ    <= '0;
    end else if (startJob) begin
      base0Q   <= i_baseAddr0;
      base1Q   <= i_baseAddr1;
      base2Q   <= i_baseAddr2;
      numFeatQ <= i_numFeat;
      featQ    <= '0;
    end else if (xfer && planeLast && !lastBeat) begin
      featQ <= featQ + 2'd1;
    end
  end

  feature_scan_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (6)
  ) u_scanCnt (
    .clk       (i_clk),
    .rstn      (i_rstn),
    .clear     (startJob),
    .advance   (xfer),
    .stride2   (stride2Q),
    .row       (row),
    .col       (col),
    .planeLast (planeLast)
  );

  assign lastBeat = (featQ == numFeatQ - 2'd1) && planeLast;

  // Base select for the current feature; only 0..2 are reachable.
  always_comb begin
    baseSel = '0;
    case (featQ)
      2'd0:    baseSel = base0Q;
      2'd1:    baseSel = base1Q;
      2'd2:    baseSel = base2Q;
      default: baseSel = '0;
    endcase
  end

  // Address comes only from registers, so it cannot move while stalled.
  assign addrCalc = baseSel + (ADDR_W'(row) << ROW_SHIFT) + ADDR_W'(col);

  assign o_valid   = isRun;
  assign o_busy    = isRun;
  assign o_done    = isDone;
  assign o_addr    = isRun ? addrCalc : '0;
  assign o_featSel = isRun ? featQ : 2'd0;
  assign o_row     = isRun ? row : 6'd0;
  assign o_col     = isRun ? col : 6'd0;
  assign o_last    = isRun & lastBeat;

endmodule

// File: tb/tb_feature_addr_gen.sv
// tb/tb_feature_addr_gen.sv - table-driven and randomized self-checking bench for feature_addr_gen
`timescale 1ns/1ps
module tb_feature_addr_gen;

  localparam int AW = 19;
`ifdef FEAT_ADDR_STRIDE2_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] b0 = '0;
  logic [AW-1:0] b1 = '0;
  logic [AW-1:0] b2 = '0;
  logic [1:0]    numFeat = 2'd0;
  logic          stride2 = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [AW-1:0] addr;
  logic [1:0]    featSel;
  logic [5:0]    row;
  logic [5:0]    col;
  logic          last;
  logic          busy;
  logic          done;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  feature_addr_gen dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .i_baseAddr0 (b0),
    .i_baseAddr1 (b1),
    .i_baseAddr2 (b2),
    .i_numFeat   (numFeat),
    .i_stride2   (stride2),
    .i_abort     (abort),
    .i_ready     (ready),
    .o_valid     (valid),
    .o_addr      (addr),
    .o_featSel   (featSel),
    .o_row       (row),
    .o_col       (col),
    .o_last      (last),
    .o_busy      (busy),
    .o_done      (done)
  );

  typedef struct {
    int addr;
    int feat;
    int row;
    int col;
  } beat_t;

  typedef struct {
    int nf;
    int x0;
    int x1;
    int x2;
    bit st;
    int rmode;
    int abortAt;
    int expBeats;
    int expFirst;
    int expLast;
    int probeIdx;
    int probeAddr;
    int expDone;
  } vec_t;

  beat_t expQ[$];
  int    gotQ[$];
  vec_t  vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference scan: every visited (feature, row, col) in order, address modulo 2^AW.
  task automatic buildModel(input int nf, input int x0, input int x1, input int x2, input bit st);
    int step;
    int bs;
    beat_t e;
    step = (st && STRIDE_EN) ? 2 : 1;
    expQ.delete();
    for (int f = 0; f < nf; f++) begin
      bs = (f == 0) ? x0 : ((f == 1) ? x1 : x2);
      for (int r = 0; r < 64; r += step) begin
        for (int c = 0; c < 64; c += step) begin
          e.addr = (bs + r * 64 + c) % (1 << AW);
          e.feat = f;
          e.row  = r;
          e.col  = c;
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic runJob(input int nf, input int x0, input int x1, input int x2, input bit st,
                        input int rmode, input int abortAt, input bit noise,
                        output int beats, output int doneCnt);
    bit    stalled;
    bit    rdy;
    bit    expLast;
    bit    finished;
    int    cyc;
    int    hAddr, hFeat, hRow, hCol;
    bit    hLast;
    beat_t e;
    stalled  = 1'b0;
    finished = 1'b0;
    cyc      = 0;
    beats    = 0;
    doneCnt  = 0;
    buildModel(nf, x0, x1, x2, st);
    gotQ.delete();
    @(negedge clk);
    b0 = AW'(x0); b1 = AW'(x1); b2 = AW'(x2);
    numFeat = 2'(nf); stride2 = st; start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("startLatencyValid", valid, (nf != 0));
    if (nf == 0) begin
      check("zeroFeatDone", done, 1);
      doneCnt = done ? 1 : 0;
      @(negedge clk);
      check("zeroFeatDonePulse", done, 0);
      check("zeroFeatNoValid", valid, 0);
      return;
    end
    while (!finished) begin
      if (cyc > 40000) begin
        nTests++; nFail++;
        $display("FAIL jobTimeout: got %0d beats, expected %0d", beats, beats + expQ.size());
        break;
      end
      if (stalled) begin
        nTests++;
        if (!valid || int'(addr) != hAddr || int'(featSel) != hFeat || int'(row) != hRow ||
            int'(col) != hCol || last != hLast) begin
          nFail++;
          $display("FAIL stallHold: got valid=%0b addr=%0d feat=%0d row=%0d col=%0d last=%0b, expected valid=1 addr=%0d feat=%0d row=%0d col=%0d last=%0b",
                   valid, addr, featSel, row, col, last, hAddr, hFeat, hRow, hCol, hLast);
        end
      end
      if (!valid) begin
        nTests++; nFail++;
        $display("FAIL validDropped: got valid=0 after %0d beats, expected 1", beats);
        break;
      end
      if (noise) begin
        start   = ($urandom_range(0, 7) == 0);
        b0      = AW'($urandom);
        numFeat = 2'($urandom);
      end
      if (abortAt > 0 && beats == abortAt) begin
        abort = 1'b1; ready = 1'b0; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abortValidLow", valid, 0);
        check("abortBusyLow", busy, 0);
        for (int k = 0; k < 3; k++) begin
          check("abortNoDone", done, 0);
          @(negedge clk);
        end
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ready   = rdy;
      expLast = 1'b0;
      if (rdy) begin
        if (expQ.size() == 0) begin
          nTests++; nFail++;
          $display("FAIL extraBeat: got addr=%0d beyond the expected %0d beats", addr, beats);
          break;
        end
        e = expQ.pop_front();
        expLast = (expQ.size() == 0);
        nTests++;
        if (int'(addr) != e.addr || int'(featSel) != e.feat || int'(row) != e.row ||
            int'(col) != e.col || last != expLast || !busy) begin
          nFail++;
          $display("FAIL beat%0d: got addr=%0d feat=%0d row=%0d col=%0d last=%0b busy=%0b, expected addr=%0d feat=%0d row=%0d col=%0d last=%0b busy=1",
                   beats, addr, featSel, row, col, last, busy, e.addr, e.feat, e.row, e.col, expLast);
        end
        gotQ.push_back(int'(addr));
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hAddr = int'(addr); hFeat = int'(featSel); hRow = int'(row); hCol = int'(col); hLast = last;
      end
      @(negedge clk);
      cyc++;
      if (expLast) begin
        start = 1'b0; ready = 1'b0;
        check("doneAfterLast", done, 1);
        check("validLowInDone", valid, 0);
        doneCnt = done ? 1 : 0;
        @(negedge clk);
        check("donePulseOneCycle", done, 0);
        finished = 1'b1;
      end
    end
    start = 1'b0;
    ready = 1'b0;
  endtask

  function automatic vec_t mk(input int nf, input int x0, input int x1, input int x2, input bit st,
                              input int rmode, input int abortAt, input int expBeats,
                              input int expFirst, input int expLast, input int probeIdx,
                              input int probeAddr, input int expDone);
    vec_t v;
    v.nf = nf; v.x0 = x0; v.x1 = x1; v.x2 = x2; v.st = st; v.rmode = rmode;
    v.abortAt = abortAt; v.expBeats = expBeats; v.expFirst = expFirst; v.expLast = expLast;
    v.probeIdx = probeIdx; v.probeAddr = probeAddr; v.expDone = expDone;
    return v;
  endfunction

  initial begin
    int beats;
    int doneCnt;
    int expN;
    int xs[3];
    bit st;
    int nf;
    int abortAt;

    vecs.push_back(mk(3, 12288, 16384, 20480, 0, 0, 0, 12288, 12288, 24575, 4096, 16384, 1));
    vecs.push_back(mk(1, 270336, 0, 0, 0, 0, 0, 4096, 270336, 274431, 4095, 274431, 1));
    vecs.push_back(mk(1, 5000, 0, 0, 0, 1, 0, 4096, 5000, 9095, 64, 5064, 1));
    vecs.push_back(mk(0, 100, 200, 300, 0, 0, 0, 0, -1, -1, 0, 0, 1));
    vecs.push_back(mk(2, 1000, 2000, 0, 0, 2, 100, 100, 1000, 1099, 64, 1064, 0));
    vecs.push_back(mk(2, 777, 50000, 0, 0, 0, 10, 10, 777, 786, 5, 782, 0));
    vecs.push_back(mk(1, 'h7FFF0, 0, 0, 0, 0, 0, 4096, 'h7FFF0, 4079, 16, 0, 1));
`ifdef FEAT_ADDR_STRIDE2_EN
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1024, 0, 4030, 32, 128, 1));
`else
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4096, 0, 4095, 64, 64, 1));
`endif

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rstValid", valid, 0);
    check("rstAddr", addr, 0);
    check("rstFeatSel", featSel, 0);
    check("rstRowCol", {row, col}, 0);
    check("rstLast", last, 0);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runJob(vecs[i].nf, vecs[i].x0, vecs[i].x1, vecs[i].x2, vecs[i].st, vecs[i].rmode,
             vecs[i].abortAt, (vecs[i].rmode == 2), beats, doneCnt);
      check($sformatf("vec%0d.beats", i), beats, vecs[i].expBeats);
      check($sformatf("vec%0d.doneCount", i), doneCnt, vecs[i].expDone);
      if (vecs[i].expBeats > 0) begin
        if (gotQ.size() > vecs[i].probeIdx) begin
          check($sformatf("vec%0d.firstAddr", i), gotQ[0], vecs[i].expFirst);
          check($sformatf("vec%0d.lastAddr", i), gotQ[gotQ.size() - 1], vecs[i].expLast);
          check($sformatf("vec%0d.probeAddr", i), gotQ[vecs[i].probeIdx], vecs[i].probeAddr);
        end else begin
          nTests++; nFail++;
          $display("FAIL vec%0d.capture: got %0d beats, expected more than %0d", i, gotQ.size(), vecs[i].probeIdx);
        end
      end
    end

    // Randomized partial jobs with noise on the start/base inputs, then one full random job.
    for (int j = 0; j < 5; j++) begin
      xs[0] = int'($urandom_range(0, (1 << AW) - 1));
      xs[1] = int'($urandom_range(0, (1 << AW) - 1));
      xs[2] = int'($urandom_range(0, (1 << AW) - 1));
      st      = 1'($urandom_range(0, 1));
      nf      = (j < 4) ? int'($urandom_range(1, 3)) : 1;
      abortAt = (j < 4) ? int'($urandom_range(20, 400)) : 0;
      runJob(nf, xs[0], xs[1], xs[2], st, 2, abortAt, 1'b1, beats, doneCnt);
      expN = (j < 4) ? abortAt : ((st && STRIDE_EN) ? 1024 : 4096);
      check($sformatf("rand%0d.beats", j), beats, expN);
      check($sformatf("rand%0d.doneCount", j), doneCnt, (j < 4) ? 0 : 1);
    end

    // Reset in the middle of a job.
    @(negedge clk);
    b0 = AW'(100); numFeat = 2'd1; stride2 = 1'b0; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("midJobRunning", valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("midRstValid", valid, 0);
    check("midRstAddr", addr, 0);
    check("midRstBusy", busy, 0);
    check("midRstDone", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postRstIdle", {valid, done}, 0);
    end
    ready = 1'b0;
    runJob(1, 0, 0, 0, 0, 0, 30, 1'b0, beats, doneCnt);
    check("postRstBeats", beats, 30);
    if (gotQ.size() > 0) check("postRstFirstAddr", gotQ[0], 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
